pio_in_edge_irq: RTL and testbench



---
 rtl/pio_in_edge_irq_pkg.sv | 23 ++
 rtl/pio_in_edge_irq_if.sv | 14 +
 rtl/pio_in_edge_irq_filter.sv | 53 +++++
 rtl/pio_in_edge_irq.sv | 92 +++++++++
 tb/tb_pio_in_edge_irq.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pio_in_edge_irq_pkg.sv
// Register map and shared helpers for the edge-capturing input PIO.
package pio_in_edge_irq_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  typedef enum logic [ADDR_W-1:0] {
    ADDR_DATA = 3'd0,
    ADDR_RISE = 3'd1,
    ADDR_FALL = 3'd2,
    ADDR_CAPT = 3'd3,
    ADDR_MASK = 3'd4,
    ADDR_PEND = 3'd5
  } reg_addr_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bundle for the input PIO register file.
interface pio_in_edge_irq_if;
  import pio_in_edge_irq_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/pio_in_edge_irq_filter.sv
// One input channel: synchroniser chain followed by an optional stable-count debounce filter.
module pio_in_filter
  import pio_in_edge_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic filt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign s = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      assign filt = s;
    end else begin : g_debounce
      localparam int CNT_W = clog2(DEBOUNCE + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

      logic [CNT_W-1:0] cnt_q;
      logic             filt_q;

      // The counter measures how long s has disagreed with filt; any agreement restarts it.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else if (s == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          filt_q <= s;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      assign filt = filt_q;
    end
  endgenerate

endmodule

// File: rtl/pio_in_edge_irq.sv
// N-bit input PIO: per-bit rise/fall capture, debounce, write-1-to-clear capture and masked irq.
module pio_in_edge_irq
  import pio_in_edge_irq_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               DEBOUNCE    = 0,
  parameter logic [WIDTH-1:0] RISE_RST    = '1,
  parameter logic [WIDTH-1:0] FALL_RST    = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pio_in_edge_irq_if.slave        bus,
  input  logic [WIDTH-1:0]        in_port,
  output logic                    irq
);

  logic [WIDTH-1:0]  filt;
  logic [WIDTH-1:0]  prev;
  logic [WIDTH-1:0]  rise_en;
  logic [WIDTH-1:0]  fall_en;
  logic [WIDTH-1:0]  edge_capture;
  logic [WIDTH-1:0]  irq_mask;
  logic [WIDTH-1:0]  edge_evt;
  logic [WIDTH-1:0]  w1c_mask;
  logic [WIDTH-1:0]  wdata;
  logic              wr_en;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pio_in_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE)
    ) u_filt (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .filt    (filt[i])
    );
  end

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;
  assign edge_evt     = (filt & ~prev & rise_en) | (~filt & prev & fall_en);
  assign w1c_mask     = (wr_en && bus.address == ADDR_CAPT) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en  <= RISE_RST;
      fall_en  <= FALL_RST;
      irq_mask <= '0;
    end else if (wr_en) begin
      if (bus.address == ADDR_RISE) rise_en  <= wdata;
      if (bus.address == ADDR_FALL) fall_en  <= wdata;
      if (bus.address == ADDR_MASK) irq_mask <= wdata;
    end
  end

  // New edges are OR-ed in after the clear so an edge landing on a W1C cycle is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      prev         <= filt;
      edge_capture <= (edge_capture & ~w1c_mask) | edge_evt;
      irq          <= |(edge_capture & irq_mask);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA: rd_mux = DATA_W'(filt);
      ADDR_RISE: rd_mux = DATA_W'(rise_en);
      ADDR_FALL: rd_mux = DATA_W'(fall_en);
      ADDR_CAPT: rd_mux = DATA_W'(edge_capture);
      ADDR_MASK: rd_mux = DATA_W'(irq_mask);
      ADDR_PEND: rd_mux = DATA_W'(edge_capture & irq_mask);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_mux;
  end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Scoreboard bench: one PIO without debounce (sel 0) and one with a 4-cycle debounce (sel 1).
module tb_pio_in_edge_irq;
  import pio_in_edge_irq_pkg::*;

  typedef struct {
    string       tag;
    int          due;
    int          sel;
    bit          is_irq;
    logic [31:0] exp;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in0;
  logic [7:0] in4;
  logic       irq0;
  logic       irq4;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  sb_item_t   sb[$];
  sb_item_t   head;

  pio_in_edge_irq_if bus0 ();
  pio_in_edge_irq_if bus4 ();

  pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in0), .irq(irq0)
  );

  pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4), .in_port(in4), .irq(irq4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel, input bit is_irq);
    if (sel == 0) return is_irq ? {31'd0, irq0} : bus0.readdata;
    return is_irq ? {31'd0, irq4} : bus4.readdata;
  endfunction

  // Outputs are registered, so the falling edge is a safe place to compare what is due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      head = sb.pop_front();
      checkOutput(head.tag, observe(head.sel, head.is_irq), head.exp);
    end
  end

  task automatic expect_at(input int sel, input bit is_irq, input int offset,
                           input logic [31:0] exp, input string tag);
    sb_item_t it;
    int pos;
    it.tag    = tag;
    it.due    = cyc + offset;
    it.sel    = sel;
    it.is_irq = is_irq;
    it.exp    = exp;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].due > it.due) pos--;
    sb.insert(pos, it);
  endtask

  task automatic drive_bus(input int sel, input logic cs, input logic wn,
                           input logic [2:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus0.chipselect = cs; bus0.write_n = wn; bus0.address = a; bus0.writedata = d;
    end else begin
      bus4.chipselect = cs; bus4.write_n = wn; bus4.address = a; bus4.writedata = d;
    end
  endtask

  // One bus cycle; for a read, d is the readdata expected one clock later.
  task automatic applyStimulus(input int sel, input bit is_write, input logic [2:0] a,
                               input logic [31:0] d, input string tag);
    @(negedge clk);
    drive_bus(sel, 1'b1, !is_write, a, d);
    if (!is_write) expect_at(sel, 1'b0, 1, d, tag);
    @(negedge clk);
    drive_bus(sel, 1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic bus_write(input int sel, input logic [2:0] a, input logic [31:0] d);
    applyStimulus(sel, 1'b1, a, d, "");
  endtask

  task automatic bus_read(input int sel, input logic [2:0] a, input logic [31:0] exp, input string tag);
    applyStimulus(sel, 1'b0, a, exp, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    in0 = 8'h00;
    in4 = 8'h00;
    drive_bus(0, 1'b0, 1'b1, 3'd0, 32'd0);
    drive_bus(1, 1'b0, 1'b1, 3'd0, 32'd0);
    idle(3);
    checkOutput("rst_irq0", {31'd0, irq0}, 32'd0);
    checkOutput("rst_rdata0", bus0.readdata, 32'd0);
    reset_n = 1'b1;
    idle(2);

    $display("[TB] reset values and register map");
    bus_read(0, ADDR_DATA, 32'h00, "rst_data");
    bus_read(0, ADDR_RISE, 32'hFF, "rst_rise");
    bus_read(0, ADDR_FALL, 32'h00, "rst_fall");
    bus_read(0, ADDR_CAPT, 32'h00, "rst_capt");
    bus_read(0, ADDR_MASK, 32'h00, "rst_mask");
    bus_read(1, ADDR_RISE, 32'hFF, "rst_rise4");
    bus_write(0, ADDR_FALL, 32'hFFFF_FF00);
    bus_read(0, ADDR_FALL, 32'h00, "fall_hi_ignored");
    bus_write(0, ADDR_FALL, 32'h0000_005A);
    bus_read(0, ADDR_FALL, 32'h5A, "fall_rw");
    bus_write(0, ADDR_FALL, 32'h0);
    bus_write(0, 3'd6, 32'hFFFF_FFFF);
    bus_read(0, 3'd6, 32'h0, "addr6_zero");
    bus_read(0, 3'd7, 32'h0, "addr7_zero");
    bus_write(0, ADDR_PEND, 32'hFF);
    bus_read(0, ADDR_PEND, 32'h0, "pend_ro");

    $display("[TB] rising-edge capture latency");
    bus_write(0, ADDR_MASK, 32'h01);
    drive_bus(0, 1'b0, 1'b1, ADDR_CAPT, 32'd0);
    in0 = 8'h01;
    expect_at(0, 1'b0, 3, 32'h00, "t1_capt_early");
    expect_at(0, 1'b0, 4, 32'h01, "t1_capt_on_time");
    expect_at(0, 1'b1, 3, 32'h0, "t1_irq_early");
    expect_at(0, 1'b1, 4, 32'h1, "t1_irq_on_time");
    idle(4);
    bus_read(0, ADDR_DATA, 32'h01, "t1_data");
    bus_write(0, ADDR_CAPT, 32'h01);
    checkOutput("t1_irq_before_clr", {31'd0, irq0}, 32'd1);
    expect_at(0, 1'b1, 1, 32'h0, "t1_irq_cleared");
    expect_at(0, 1'b0, 1, 32'h0, "t1_capt_cleared");
    idle(1);

    $display("[TB] falling edges and W1C");
    bus_write(0, ADDR_RISE, 32'h00);
    bus_write(0, ADDR_FALL, 32'hF0);
    in0 = 8'hFF;
    idle(4);
    bus_read(0, ADDR_CAPT, 32'h00, "t2_rise_disabled");
    in0 = 8'h0F;
    idle(4);
    bus_read(0, ADDR_CAPT, 32'hF0, "t2_fall_capt");
    bus_read(0, ADDR_DATA, 32'h0F, "t2_data");
    checkOutput("t2_irq_masked", {31'd0, irq0}, 32'd0);
    bus_write(0, ADDR_CAPT, 32'h30);
    bus_read(0, ADDR_CAPT, 32'hC0, "t2_w1c");
    bus_read(0, ADDR_PEND, 32'h00, "t2_pend");

    $display("[TB] clear and edge in the same cycle");
    bus_write(0, ADDR_FALL, 32'h00);
    bus_write(0, ADDR_RISE, 32'h01);
    bus_write(0, ADDR_CAPT, 32'hFF);
    in0 = 8'h0E;
    idle(4);
    in0 = 8'h0F;
    idle(4);
    bus_read(0, ADDR_CAPT, 32'h01, "t4_setup");
    bus_write(0, ADDR_CAPT, 32'h01);
    bus_read(0, ADDR_CAPT, 32'h00, "t4_w1c");
    in0 = 8'h0E;
    idle(4);
    in0 = 8'h0F;
    idle(2);
    drive_bus(0, 1'b1, 1'b0, ADDR_CAPT, 32'h01);
    idle(1);
    drive_bus(0, 1'b0, 1'b1, ADDR_CAPT, 32'h0);
    bus_read(0, ADDR_CAPT, 32'h01, "t4_set_wins");
    bus_write(0, ADDR_CAPT, 32'h01);
    bus_read(0, ADDR_CAPT, 32'h00, "t4_clear_after");

    $display("[TB] masking and pending");
    bus_write(0, ADDR_MASK, 32'h04);
    bus_write(0, ADDR_RISE, 32'h05);
    in0 = 8'h0A;
    idle(4);
    in0 = 8'h0F;
    idle(5);
    bus_read(0, ADDR_CAPT, 32'h05, "t5_capt");
    bus_read(0, ADDR_PEND, 32'h04, "t5_pend");
    checkOutput("t5_irq", {31'd0, irq0}, 32'd1);
    bus_write(0, ADDR_MASK, 32'h00);
    checkOutput("t5_irq_lag_mask", {31'd0, irq0}, 32'd1);
    expect_at(0, 1'b1, 1, 32'h0, "t5_irq_masked");
    idle(1);
    bus_write(0, ADDR_MASK, 32'h01);
    checkOutput("t5_irq_lag_unmask", {31'd0, irq0}, 32'd0);
    expect_at(0, 1'b1, 1, 32'h1, "t5_irq_unmasked");
    idle(1);
    bus_write(0, ADDR_RISE, 32'h00);
    bus_read(0, ADDR_CAPT, 32'h05, "t5_capt_kept");
    bus_read(0, ADDR_DATA, 32'h0F, "t5_data");

    $display("[TB] debounce");
    in4 = 8'h04;
    idle(3);
    in4 = 8'h00;
    idle(10);
    bus_read(1, ADDR_DATA, 32'h00, "t3_glitch_data");
    bus_read(1, ADDR_CAPT, 32'h00, "t3_glitch_capt");
    drive_bus(1, 1'b0, 1'b1, ADDR_DATA, 32'd0);
    in4 = 8'h04;
    expect_at(1, 1'b0, 6, 32'h00, "t3_data_early");
    expect_at(1, 1'b0, 7, 32'h04, "t3_data_on_time");
    idle(7);
    bus_read(1, ADDR_CAPT, 32'h04, "t3_capt");

    $display("[TB] asynchronous reset and strap capture");
    bus_write(1, ADDR_MASK, 32'h04);
    idle(1);
    checkOutput("t6_irq_pending", {31'd0, irq4}, 32'd1);
    in4 = 8'h05;
    idle(3);
    drive_bus(1, 1'b0, 1'b1, ADDR_CAPT, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_irq4", {31'd0, irq4}, 32'd0);
    checkOutput("t6_rst_rdata4", bus4.readdata, 32'd0);
    checkOutput("t6_rst_irq0", {31'd0, irq0}, 32'd0);
    in4 = 8'h01;
    idle(2);
    reset_n = 1'b1;
    expect_at(1, 1'b0, 7, 32'h00, "t6_strap_early");
    expect_at(1, 1'b0, 8, 32'h01, "t6_strap_on_time");
    expect_at(1, 1'b1, 9, 32'h0, "t6_irq_after_rst");
    idle(9);
    bus_read(1, ADDR_MASK, 32'h00, "t6_mask");
    bus_read(1, ADDR_RISE, 32'hFF, "t6_rise");
    bus_read(1, ADDR_DATA, 32'h01, "t6_data");

    idle(3);
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
